llc_set_assoc: RTL and testbench
================================

LLC_SET_ASSOC -- requirements
Module: llc_set_assoc

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways per set (power of two, 1..8).
REQ-002 SHALL have parameter SETS, default 32, number of sets (power of two).
REQ-003 SHALL have parameter LINE_BYTES, default 64, bytes per line; AXI_DATA_W, default 64, AXI read data width; BEATS = LINE_BYTES*8/AXI_DATA_W.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- S_R_ADDR  in  64  byte address of the request.
- S_R_ADDR_VALID  in  1  request valid.
- S_R_READY  out  1  request accepted when high with S_R_ADDR_VALID.
- S_R_DATA  out  LINE_BYTES*8  returned line.
- S_R_DATA_VALID  out  1  one-cycle response strobe.
- INV  in  1  invalidate-all pulse.
- m_axi_araddr  out  64  line-aligned fill address.
- m_axi_arlen  out  8  burst length, constant BEATS-1.
- m_axi_arvalid  out  1  address valid.
- m_axi_arready  in  1  address ready.
- m_axi_rdata  in  AXI_DATA_W  read data.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rlast  in  1  last beat of the burst.
- m_axi_rready  out  1  read data ready.
- hit_count  out  32  number of hits.
- miss_count  out  32  number of misses.

Function
REQ-005 SHALL split the address into offset = log2(LINE_BYTES) bits, index = log2(SETS) bits, and tag = the remaining upper bits.
REQ-006 SHALL implement the FSM states IDLE, AR, FILL and RESP; S_R_READY SHALL be high only in IDLE with no invalidate pending.
REQ-007 On an accepted hit (a valid way with a matching tag in the indexed set), the FSM SHALL stay in IDLE and drive S_R_DATA_VALID=1 with the hit line exactly one cycle later.
REQ-008 On an accepted miss, the block SHALL latch the address and victim way, clear the victim's valid bit, and go to AR.
REQ-009 Victim selection: the lowest-numbered invalid way; otherwise the set's round-robin pointer, which SHALL advance (mod WAYS) on each fill of that set.
REQ-010 In AR: m_axi_arvalid=1 and m_axi_araddr = latched address with offset bits zeroed, held stable until m_axi_arready; then go to FILL.
REQ-011 In FILL: m_axi_rready=1; beat k (k = 0..BEATS-1) SHALL write bits [k*AXI_DATA_W +: AXI_DATA_W] of the victim line; the beat counter SHALL saturate at BEATS-1; beats arriving after saturation SHALL be dropped.
REQ-012 A beat with m_axi_rlast=1 SHALL set the victim's tag and valid bit and move to RESP, regardless of the beat count.
REQ-013 In RESP: S_R_DATA_VALID=1 for one cycle with the filled line, then go to IDLE; miss-to-response latency is therefore the AXI latency plus 1 cycle.
REQ-014 INV in any cycle SHALL set a pending flag; on the first cycle in IDLE with the flag set, the block SHALL clear all valid bits and the flag, and accept no request in that cycle.
REQ-015 INV arriving during AR/FILL SHALL NOT abort the fill; the fill SHALL complete, respond, and the line SHALL then be invalidated.
REQ-016 An INV pulse and a request in the same IDLE cycle: the invalidate SHALL win, and the request SHALL be held off by S_R_READY=0.

Reset
REQ-017 While reset=0: FSM=IDLE, all valid bits 0, all round-robin pointers 0, invalidate-pending flag 0, S_R_DATA_VALID/m_axi_arvalid/m_axi_rready=0, m_axi_araddr=0, counters 0.
REQ-018 Reset asserted mid-fill SHALL abandon the burst immediately; the line data array SHALL NOT be reset.

Configuration
REQ-019 With LLC_PERF_CNT_EN defined, hit_count/miss_count SHALL increment on each accepted hit/miss, wrapping at 2^32.
REQ-020 Without LLC_PERF_CNT_EN, the counter ports SHALL remain and SHALL be tied to 0, with no counter flops.

Structure
REQ-021 Package llc_pkg SHALL hold the FSM state enum, the line-metadata struct (valid, tag) and the AXI burst constants.
REQ-022 Sub-module llc_way_sel SHALL perform the combinational hit compare and victim/round-robin selection for one set.

Verification
REQ-023 The bench SHALL cover: read 0x1000 cold -> araddr=0x1000, arlen=7, 8 beats 0..7 -> S_R_DATA_VALID with beat k in bits [64k+63:64k].
REQ-024 The bench SHALL cover: re-read 0x1010 -> S_R_DATA_VALID exactly 1 cycle after acceptance, no AR issued, hit_count=1.
REQ-025 The bench SHALL cover: reads 0x1800 then 0x2000 (same set 0) -> 0x2000 evicts way 0 (0x1000); a following read of 0x1000 misses.
REQ-026 The bench SHALL cover: INV pulsed during FILL of 0x3000 -> response still returned; the next read of 0x3000 misses.
REQ-027 The bench SHALL cover: rlast on beat 3 of 8 -> line valid, RESP issued; and reset=0 during FILL -> outputs cleared, next read misses.

Source files
------------

// File: rtl/llc_pkg.sv
// Shared types and AXI constants for the llc_set_assoc last-level cache.
package llc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StFill,
    StResp
  } llc_state_e;

  // Tag is held zero-extended to the full address width so the struct is parameter-free.
  typedef struct packed {
    logic        valid;
    logic [63:0] tag;
  } llc_meta_t;

  localparam int unsigned AxiAddrW  = 64;
  localparam int unsigned AxiArLenW = 8;

  function automatic logic [AxiArLenW-1:0] llc_arlen(input int unsigned beats);
    return AxiArLenW'(beats - 1);
  endfunction

endpackage

// File: rtl/llc_way_sel.sv
// Combinational hit compare and victim selection across the ways of one set.
module llc_way_sel
  import llc_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]    i_valid,
  input  logic [WAYS*64-1:0] i_tags,
  input  logic [63:0]        i_tag,
  input  logic [WAY_W-1:0]   i_rr,
  output logic               o_hit,
  output logic [WAY_W-1:0]   o_hit_way,
  output logic [WAY_W-1:0]   o_victim
);

  logic             w_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_has_inv;
  logic [WAY_W-1:0] w_inv_way;

  // Lowest-numbered match / invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit && i_valid[w] && (i_tags[w*64 +: 64] == i_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_has_inv && !i_valid[w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign o_hit     = w_hit;
  assign o_hit_way = w_hit_way;
  assign o_victim  = w_has_inv ? w_inv_way : i_rr;

endmodule

// File: rtl/llc_set_assoc.sv
// Read-only set-associative last-level cache with an AXI burst refill port.
// Define LLC_PERF_CNT_EN to build the hit/miss counters; otherwise they read as zero.
module llc_set_assoc
  import llc_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned AXI_DATA_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [63:0]             S_R_ADDR,
  input  logic                    S_R_ADDR_VALID,
  output logic                    S_R_READY,
  output logic [LINE_BYTES*8-1:0] S_R_DATA,
  output logic                    S_R_DATA_VALID,
  input  logic                    INV,
  output logic [63:0]             m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [AXI_DATA_W-1:0]   m_axi_rdata,
  input  logic                    m_axi_rvalid,
  input  logic                    m_axi_rlast,
  output logic                    m_axi_rready,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int unsigned LINE_W   = LINE_BYTES * 8;
  localparam int unsigned BEATS    = LINE_W / AXI_DATA_W;
  localparam int unsigned OFF_W    = $clog2(LINE_BYTES);
  localparam int unsigned IDX_BITS = $clog2(SETS);
  localparam int unsigned IDX_W    = (SETS > 1) ? IDX_BITS : 1;
  localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  llc_state_e          r_state, w_state_d;
  llc_meta_t           r_meta [SETS][WAYS];
  logic [WAY_W-1:0]    r_rr   [SETS];
  logic [LINE_W-1:0]   r_data [SETS][WAYS];
  logic                r_inv_pend;
  logic                r_hit_q;
  logic [63:0]         r_araddr;
  logic [IDX_W-1:0]    r_idx;
  logic [WAY_W-1:0]    r_way;
  logic [63:0]         r_tag;
  logic [BEAT_W-1:0]   r_beat;
  logic                r_beat_sat;

  logic [IDX_W-1:0]    w_idx;
  logic [63:0]         w_tag;
  logic [WAYS-1:0]     w_set_valid;
  logic [WAYS*64-1:0]  w_set_tags;
  logic                w_hit;
  logic [WAY_W-1:0]    w_hit_way;
  logic [WAY_W-1:0]    w_victim;
  logic                w_acc;
  logic                w_inv_clr;
  logic                w_beat_in;

  assign w_idx = IDX_W'((S_R_ADDR >> OFF_W) & 64'(SETS - 1));
  assign w_tag = S_R_ADDR >> (OFF_W + IDX_BITS);

  always_comb begin
    w_set_valid = '0;
    w_set_tags  = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_set_valid[w]         = r_meta[w_idx][w].valid;
      w_set_tags[w*64 +: 64] = r_meta[w_idx][w].tag;
    end
  end

  llc_way_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_way_sel (
    .i_valid   (w_set_valid),
    .i_tags    (w_set_tags),
    .i_tag     (w_tag),
    .i_rr      (r_rr[w_idx]),
    .o_hit     (w_hit),
    .o_hit_way (w_hit_way),
    .o_victim  (w_victim)
  );

  // A pending or same-cycle invalidate blocks acceptance in IDLE.
  always_comb begin
    w_state_d     = r_state;
    S_R_READY     = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    w_acc         = 1'b0;
    w_inv_clr     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_inv_pend) begin
          w_inv_clr = 1'b1;
        end else begin
          S_R_READY = !INV;
          w_acc     = S_R_ADDR_VALID && !INV;
          if (w_acc && !w_hit) w_state_d = StAr;
        end
      end
      StAr: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) w_state_d = StFill;
      end
      StFill: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) w_state_d = StResp;
      end
      StResp: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_beat_in = (r_state == StFill) && m_axi_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_inv_pend <= 1'b0;
      r_hit_q    <= 1'b0;
      r_araddr   <= '0;
      r_idx      <= '0;
      r_way      <= '0;
      r_tag      <= '0;
      r_beat     <= '0;
      r_beat_sat <= 1'b0;
      for (int unsigned s = 0; s < SETS; s++) begin
        r_rr[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) r_meta[s][w] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_hit_q <= w_acc && w_hit;
      if (w_inv_clr) begin
        r_inv_pend <= 1'b0;
        for (int unsigned s = 0; s < SETS; s++) begin
          for (int unsigned w = 0; w < WAYS; w++) r_meta[s][w].valid <= 1'b0;
        end
      end
      if (INV) r_inv_pend <= 1'b1;
      if (w_acc) begin
        r_idx <= w_idx;
        if (w_hit) begin
          r_way <= w_hit_way;
        end else begin
          r_way                        <= w_victim;
          r_tag                        <= w_tag;
          r_araddr                     <= S_R_ADDR & ~64'(LINE_BYTES - 1);
          r_meta[w_idx][w_victim].valid <= 1'b0;
          r_beat                       <= '0;
          r_beat_sat                   <= 1'b0;
        end
      end
      if (w_beat_in) begin
        if (!r_beat_sat) begin
          if (r_beat == BEAT_W'(BEATS - 1)) r_beat_sat <= 1'b1;
          else                              r_beat     <= r_beat + 1'b1;
        end
        // rlast commits the line even on a short burst.
        if (m_axi_rlast) begin
          r_meta[r_idx][r_way] <= '{valid: 1'b1, tag: r_tag};
          r_rr[r_idx] <= (r_rr[r_idx] == WAY_W'(WAYS - 1)) ? '0 : r_rr[r_idx] + 1'b1;
        end
      end
    end
  end

  // Line storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_beat_in && !r_beat_sat) begin
      r_data[r_idx][r_way][int'(r_beat)*AXI_DATA_W +: AXI_DATA_W] <= m_axi_rdata;
    end
  end

  assign S_R_DATA       = r_data[r_idx][r_way];
  assign S_R_DATA_VALID = r_hit_q || (r_state == StResp);
  assign m_axi_araddr   = r_araddr;
  assign m_axi_arlen    = llc_arlen(BEATS);

`ifdef LLC_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (w_acc) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_llc_set_assoc.sv
// Self-checking bench for llc_set_assoc: directed table, corner sequences, random vs model.
module tb_llc_set_assoc;

  localparam int unsigned WAYS       = 2;
  localparam int unsigned SETS       = 32;
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned AXI_DATA_W = 64;
  localparam int unsigned LINE_W     = LINE_BYTES * 8;
  localparam int unsigned BEATS      = LINE_W / AXI_DATA_W;
`ifdef LLC_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [63:0]       S_R_ADDR;
  logic              S_R_ADDR_VALID;
  logic              S_R_READY;
  logic [LINE_W-1:0] S_R_DATA;
  logic              S_R_DATA_VALID;
  logic              INV;
  logic [63:0]       m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [63:0]       m_axi_rdata;
  logic              m_axi_rvalid;
  logic              m_axi_rlast;
  logic              m_axi_rready;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  llc_set_assoc #(
    .WAYS       (WAYS),
    .SETS       (SETS),
    .LINE_BYTES (LINE_BYTES),
    .AXI_DATA_W (AXI_DATA_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .S_R_ADDR       (S_R_ADDR),
    .S_R_ADDR_VALID (S_R_ADDR_VALID),
    .S_R_READY      (S_R_READY),
    .S_R_DATA       (S_R_DATA),
    .S_R_DATA_VALID (S_R_DATA_VALID),
    .INV            (INV),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rvalid   (m_axi_rvalid),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rready   (m_axi_rready),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per set, per way contents plus a replacement pointer.
  bit              m_valid [SETS][WAYS];
  logic [63:0]     m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data [SETS][WAYS];
  logic [BEATS-1:0]  m_known [SETS][WAYS];
  int              m_rr    [SETS];
  int              m_hits;
  int              m_misses;

  typedef struct {
    logic [63:0] addr;
    bit          exp_hit;
    int          rlast_beat;
    int          inv_beat;
    logic [31:0] base;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp, input logic [BEATS-1:0] mask);
    int badk;
    badk = -1;
    total++;
    for (int k = BEATS - 1; k >= 0; k--) begin
      if (mask[k] && (act[k*64 +: 64] !== exp[k*64 +: 64])) badk = k;
    end
    if (badk >= 0) begin
      bad++;
      $display("FAIL %s beat %0d: got %h want %h", name, badk, act[badk*64 +: 64],
               exp[badk*64 +: 64]);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_known[s][w] = '0;
      end
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_inv();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
  endtask

  function automatic int model_find(input int set, input logic [63:0] tag);
    for (int w = 0; w < WAYS; w++)
      if (m_valid[set][w] && m_tag[set][w] == tag) return w;
    return -1;
  endfunction

  task automatic model_victim(input int set, output int way);
    way = m_rr[set];
    for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) way = w;
    m_valid[set][way] = 1'b0;
  endtask

  task automatic model_fill(input int set, input int way, input logic [63:0] tag,
                            input logic [LINE_W-1:0] line, input int nb);
    for (int k = 0; k < nb; k++) begin
      m_data[set][way][k*64 +: 64] = line[k*64 +: 64];
      m_known[set][way][k] = 1'b1;
    end
    m_valid[set][way] = 1'b1;
    m_tag[set][way]   = tag;
    m_rr[set]         = (m_rr[set] + 1) % WAYS;
  endtask

  // Entered and left #1 after a rising edge.
  task automatic do_read(input logic [63:0] addr, input bit exp_hit, input int rlast_beat,
                         input int inv_beat, input logic [31:0] base);
    int set, way, nb, w, gap;
    logic [63:0] tag, al;
    logic [LINE_W-1:0] line;
    logic [BEATS-1:0] newmask;
    bit acc, bad_hold, early, no_rready;
    set = int'((addr / LINE_BYTES) % SETS);
    tag = addr / (LINE_BYTES * SETS);
    al  = (addr / LINE_BYTES) * LINE_BYTES;
    S_R_ADDR = addr;
    S_R_ADDR_VALID = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (S_R_READY) begin
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("req_accept", acc, 1);
    if (!acc) begin
      S_R_ADDR_VALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    S_R_ADDR_VALID = 1'b0;
    @(negedge clk);
    if (exp_hit) begin
      way = model_find(set, tag);
      m_hits++;
      chk("hit_resp_valid", S_R_DATA_VALID, 1);
      chk("hit_no_ar", m_axi_arvalid, 0);
      if (way >= 0) chk_line("hit_data", S_R_DATA, m_data[set][way], m_known[set][way]);
      @(posedge clk); #1;
      return;
    end
    m_misses++;
    model_victim(set, way);
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_addr", m_axi_araddr, al);
    chk("ar_len", m_axi_arlen, BEATS - 1);
    chk("miss_no_early", S_R_DATA_VALID, 0);
    bad_hold = 1'b0;
    w = $urandom_range(0, 3);
    for (int i = 0; i < w; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!m_axi_arvalid || m_axi_araddr !== al) bad_hold = 1'b1;
    end
    chk("ar_hold", bad_hold, 0);
    @(posedge clk); #1;
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    nb = (rlast_beat < 0) ? BEATS : rlast_beat + 1;
    line = '0;
    newmask = '0;
    early = 1'b0;
    no_rready = 1'b0;
    for (int k = 0; k < nb; k++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (S_R_DATA_VALID) early = 1'b1;
        @(posedge clk); #1;
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = {base, 32'(k)};
      m_axi_rlast  = (k == nb - 1);
      INV          = (k == inv_beat);
      line[k*64 +: 64] = m_axi_rdata;
      newmask[k] = 1'b1;
      @(negedge clk);
      if (!m_axi_rready) no_rready = 1'b1;
      if (S_R_DATA_VALID) early = 1'b1;
      @(posedge clk); #1;
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      INV          = 1'b0;
    end
    @(negedge clk);
    chk("fill_rready", no_rready, 0);
    chk("fill_no_early", early, 0);
    chk("miss_resp_valid", S_R_DATA_VALID, 1);
    model_fill(set, way, tag, line, nb);
    chk_line("miss_data", S_R_DATA, m_data[set][way], newmask);
    if (inv_beat >= 0 && inv_beat < nb) model_inv();
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_one_cycle", S_R_DATA_VALID, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ra;
    bit rh;
    int ib;
    vecs[0] = '{64'h1000, 1'b0, -1, -1, 32'h0};
    vecs[1] = '{64'h1010, 1'b1, -1, -1, 32'h0};
    vecs[2] = '{64'h1800, 1'b0, -1, -1, 32'h18};
    vecs[3] = '{64'h2000, 1'b0, -1, -1, 32'h20};
    vecs[4] = '{64'h1000, 1'b0, -1, -1, 32'h10};
    vecs[5] = '{64'h2008, 1'b1, -1, -1, 32'h0};
    vecs[6] = '{64'h3000, 1'b0, -1,  4, 32'h30};
    vecs[7] = '{64'h3000, 1'b0, -1, -1, 32'h31};
    vecs[8] = '{64'h4000, 1'b0,  3, -1, 32'h40};
    vecs[9] = '{64'h4020, 1'b1, -1, -1, 32'h0};

    reset = 1'b0;
    S_R_ADDR = '0;
    S_R_ADDR_VALID = 1'b0;
    INV = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata = '0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", S_R_DATA_VALID, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_ready", S_R_READY, 1);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_read(vecs[i].addr, vecs[i].exp_hit, vecs[i].rlast_beat, vecs[i].inv_beat,
              vecs[i].base);
      if (i == 1) chk("hit_count_after_rehit", hit_count, Perf ? 1 : 0);
    end

    // Invalidate and request in the same idle cycle.
    INV = 1'b1;
    S_R_ADDR = 64'h4000;
    S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    chk("inv_req_ready", S_R_READY, 0);
    @(posedge clk); #1;
    INV = 1'b0;
    @(negedge clk);
    chk("inv_pend_ready", S_R_READY, 0);
    @(posedge clk); #1;
    S_R_ADDR_VALID = 1'b0;
    model_inv();
    do_read(64'h4000, 1'b0, -1, -1, 32'h41);
    chk("hit_count_mid", hit_count, Perf ? m_hits : 0);
    chk("miss_count_mid", miss_count, Perf ? m_misses : 0);

    // Reset in the middle of a burst.
    S_R_ADDR = 64'h5000;
    S_R_ADDR_VALID = 1'b1;
    @(negedge clk);
    chk("rstfill_ready", S_R_READY, 1);
    @(posedge clk); #1;
    S_R_ADDR_VALID = 1'b0;
    m_axi_arready = 1'b1;
    @(posedge clk); #1;
    m_axi_arready = 1'b0;
    m_axi_rvalid = 1'b1;
    m_axi_rdata = 64'hdead_0000;
    @(posedge clk); #1;
    m_axi_rdata = 64'hdead_0001;
    @(posedge clk); #1;
    m_axi_rvalid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("rstfill_resp_valid", S_R_DATA_VALID, 0);
    chk("rstfill_arvalid", m_axi_arvalid, 0);
    chk("rstfill_rready", m_axi_rready, 0);
    chk("rstfill_araddr", m_axi_araddr, 0);
    chk("rstfill_miss_count", miss_count, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    do_read(64'h5000, 1'b0, -1, -1, 32'h50);

    for (int n = 0; n < 60; n++) begin
      ra = 64'h10000 + 64'($urandom_range(0, 4)) * SETS * LINE_BYTES
         + 64'($urandom_range(0, 2)) * LINE_BYTES + 64'($urandom_range(0, 63));
      rh = model_find(int'((ra / LINE_BYTES) % SETS), ra / (LINE_BYTES * SETS)) >= 0;
      ib = (!rh && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
      do_read(ra, rh, -1, ib, $urandom);
    end
    chk("final_hit_count", hit_count, Perf ? m_hits : 0);
    chk("final_miss_count", miss_count, Perf ? m_misses : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
